// File: rtl/inst_encoder_loader.sv
// Packs instruction field bundles into 32-bit ISA words and streams them into
// consecutive instruction-memory locations through a ready-handshaked write port.
module inst_encoder_loader #(
  parameter int            AW        = 8,
  parameter logic [AW-1:0] BASE_ADDR = '0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clear,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [2:0]    in_opcode,
  input  logic [4:0]    in_r0,
  input  logic [4:0]    in_r1,
  input  logic [4:0]    in_r2,
  input  logic [15:0]   in_addr,
  output logic          mem_we,
  input  logic          mem_ready,
  output logic [AW-1:0] mem_waddr,
  output logic [31:0]   mem_wdata,
  output logic [AW:0]   wcount,
  output logic          full,
  output logic          err,
  output logic [7:0]    err_cnt
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    FULL  = 2'd2
  } state_t;

  localparam logic [AW:0] DEPTH_CNT = {1'b1, {AW{1'b0}}};
  localparam logic [AW:0] LAST_CNT  = DEPTH_CNT - 1'b1;

  state_t          state_q, state_d;
  logic [AW-1:0]   ptr_q, ptr_d;
  logic [AW:0]     wcount_q, wcount_d;
  logic [31:0]     wdata_q, wdata_d;
  logic            err_q, err_d;
  logic [7:0]      err_cnt_q, err_cnt_d;
  logic            addr_ok;
  logic [31:0]     enc_word;

  // Opcode class picks the immediate width: 16 bits for 0-1, 15 for 2-3, 14 for 4-7.
  function automatic logic addr_in_range(input logic [2:0] op, input logic [15:0] addr);
    logic ok;
    if (op[2])      ok = (addr[15:14] == 2'b00);
    else if (op[1]) ok = ~addr[15];
    else            ok = 1'b1;
    return ok;
  endfunction

  function automatic logic [31:0] encode_inst(input logic [2:0]  op,
                                              input logic [4:0]  r0,
                                              input logic [4:0]  r1,
                                              input logic [4:0]  r2,
                                              input logic [15:0] addr);
    logic [31:0] w;
    if (op[2])      w = {op, r0, r1, r2, addr[13:0]};
    else if (op[1]) w = {op, r0, r1, 4'b0000, addr[14:0]};
    else            w = {op, r0, 3'b000, r1, addr};
    return w;
  endfunction

  assign addr_ok  = addr_in_range(in_opcode, in_addr);
  assign enc_word = encode_inst(in_opcode, in_r0, in_r1, in_r2, in_addr);

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    wcount_d  = wcount_q;
    wdata_d   = wdata_q;
    err_d     = 1'b0;
    err_cnt_d = err_cnt_q;
    if (clear) begin
      // A pending write is abandoned even if memory would have taken it this cycle.
      state_d  = IDLE;
      ptr_d    = BASE_ADDR;
      wcount_d = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            if (addr_ok) begin
              wdata_d = enc_word;
              state_d = WRITE;
            end else begin
              err_d = 1'b1;
              if (err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
            end
          end
        end
        WRITE: begin
          if (mem_ready) begin
            ptr_d    = ptr_q + 1'b1;
            wcount_d = wcount_q + 1'b1;
            state_d  = (wcount_q == LAST_CNT) ? FULL : IDLE;
          end
        end
        FULL:    state_d = FULL;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      ptr_q     <= BASE_ADDR;
      wcount_q  <= '0;
      wdata_q   <= '0;
      err_q     <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      wcount_q  <= wcount_d;
      wdata_q   <= wdata_d;
      err_q     <= err_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign in_ready  = rst_n & (state_q == IDLE) & ~clear;
  assign mem_we    = (state_q == WRITE);
  assign mem_waddr = ptr_q;
  assign mem_wdata = wdata_q;
  assign wcount    = wcount_q;
  assign full      = (state_q == FULL);
  assign err       = err_q;
  assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_inst_encoder_loader.sv
// Directed scenarios plus randomized traffic for inst_encoder_loader, checked every
// cycle against a word-count based reference model.
module tb_inst_encoder_loader;

  localparam int            AW    = 2;
  localparam int            DEPTH = 1 << AW;
  localparam int            BASE  = 2;
  localparam logic [AW-1:0] BASE_P = 2'd2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          clear = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [2:0]    in_opcode = '0;
  logic [4:0]    in_r0 = '0, in_r1 = '0, in_r2 = '0;
  logic [15:0]   in_addr = '0;
  logic          mem_we;
  logic          mem_ready = 1'b0;
  logic [AW-1:0] mem_waddr;
  logic [31:0]   mem_wdata;
  logic [AW:0]   wcount;
  logic          full;
  logic          err;
  logic [7:0]    err_cnt;

  int total = 0;
  int bad   = 0;

  inst_encoder_loader #(.AW(AW), .BASE_ADDR(BASE_P)) u_dut (
    .clk(clk), .rst_n(rst_n), .clear(clear),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_opcode(in_opcode), .in_r0(in_r0), .in_r1(in_r1), .in_r2(in_r2), .in_addr(in_addr),
    .mem_we(mem_we), .mem_ready(mem_ready), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
    .wcount(wcount), .full(full), .err(err), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference encoding from field positions expressed as powers of two.
  function automatic logic [31:0] ref_enc(input int op, input int r0, input int r1,
                                          input int r2, input int addr);
    longint w;
    w = longint'(op) * (64'd1 << 29) + longint'(r0) * (64'd1 << 24);
    if (op < 2)      w += longint'(r1) * 65536 + addr;
    else if (op < 4) w += longint'(r1) * (64'd1 << 19) + addr;
    else             w += longint'(r1) * (64'd1 << 19) + longint'(r2) * (64'd1 << 14) + addr;
    return w[31:0];
  endfunction

  function automatic int ref_limit(input int op);
    return (op < 2) ? 65535 : (op < 4) ? 32767 : 16383;
  endfunction

  // Model state: words written since clear, whether a word is waiting, rejection tally.
  int          m_cnt = 0;
  int          m_errcnt = 0;
  bit          m_pend = 0;
  bit          m_err = 0;
  logic [31:0] m_word = '0;

  always @(negedge clk) begin
    if (!rst_n) begin
      m_cnt = 0; m_errcnt = 0; m_pend = 0; m_err = 0; m_word = '0;
    end
    check_eq("m_in_ready", 32'(in_ready), 32'(rst_n && !m_pend && m_cnt != DEPTH && !clear));
    check_eq("m_mem_we", 32'(mem_we), 32'(m_pend));
    check_eq("m_waddr", 32'(mem_waddr), 32'((BASE + m_cnt) % DEPTH));
    check_eq("m_wdata", mem_wdata, m_word);
    check_eq("m_wcount", 32'(wcount), 32'(m_cnt));
    check_eq("m_full", 32'(full), 32'(m_cnt == DEPTH));
    check_eq("m_err", 32'(err), 32'(m_err));
    check_eq("m_err_cnt", 32'(err_cnt), 32'(m_errcnt));
    if (rst_n) begin
      m_err = 0;
      if (clear) begin
        m_pend = 0;
        m_cnt  = 0;
      end else if (m_pend) begin
        if (mem_ready) begin
          m_pend = 0;
          m_cnt++;
        end
      end else if (m_cnt < DEPTH && in_valid) begin
        if (int'(in_addr) > ref_limit(int'(in_opcode))) begin
          m_err = 1;
          if (m_errcnt < 255) m_errcnt++;
        end else begin
          m_pend = 1;
          m_word = ref_enc(in_opcode, in_r0, in_r1, in_r2, in_addr);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int op, input int r0, input int r1, input int r2, input int addr);
    in_valid  = 1'b1;
    in_opcode = 3'(op);
    in_r0     = 5'(r0);
    in_r1     = 5'(r1);
    in_r2     = 5'(r2);
    in_addr   = 16'(addr);
    tick();
    in_valid  = 1'b0;
  endtask

  initial begin
    int exp_addr[4] = '{2, 3, 0, 1};

    // Reset and first encode
    tick(); tick();
    rst_n = 1'b1;
    tick();
    mem_ready = 1'b1;
    send(4, 3, 5, 7, 16'h1234);
    @(negedge clk);
    check_eq("t1_we", 32'(mem_we), 32'd1);
    check_eq("t1_wdata", mem_wdata, 32'h8329D234);
    check_eq("t1_waddr", 32'(mem_waddr), 32'd2);
    tick();
    @(negedge clk);
    check_eq("t1_we_drop", 32'(mem_we), 32'd0);
    check_eq("t1_wcount", 32'(wcount), 32'd1);

    // Two formats, consecutive addresses with wrap
    tick();
    send(0, 1, 2, 0, 16'hBEEF);
    @(negedge clk);
    check_eq("t2_wdata_a", mem_wdata, 32'h0102BEEF);
    check_eq("t2_waddr_a", 32'(mem_waddr), 32'd3);
    tick();
    send(2, 31, 31, 0, 16'h7FFF);
    @(negedge clk);
    check_eq("t2_wdata_b", mem_wdata, 32'h5FF87FFF);
    check_eq("t2_waddr_b", 32'(mem_waddr), 32'd0);
    tick();
    @(negedge clk);
    check_eq("t2_wcount", 32'(wcount), 32'd3);

    // Out-of-range immediates are rejected
    tick();
    send(2, 0, 0, 0, 16'h8000);
    @(negedge clk);
    check_eq("t3_err_a", 32'(err), 32'd1);
    check_eq("t3_we_a", 32'(mem_we), 32'd0);
    tick();
    send(5, 0, 0, 0, 16'h4000);
    @(negedge clk);
    check_eq("t3_err_b", 32'(err), 32'd1);
    tick();
    @(negedge clk);
    check_eq("t3_err_pulse", 32'(err), 32'd0);
    check_eq("t3_err_cnt", 32'(err_cnt), 32'd2);
    check_eq("t3_wcount", 32'(wcount), 32'd3);

    tick();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    @(negedge clk);
    check_eq("clr_wcount", 32'(wcount), 32'd0);

    // Memory back-pressure holds the request stable
    tick();
    mem_ready = 1'b0;
    send(7, 1, 1, 1, 16'h0ABC);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check_eq("t4_we_hold", 32'(mem_we), 32'd1);
      check_eq("t4_waddr_hold", 32'(mem_waddr), 32'd2);
      check_eq("t4_wdata_hold", mem_wdata, ref_enc(7, 1, 1, 1, 16'h0ABC));
      check_eq("t4_ready_low", 32'(in_ready), 32'd0);
      tick();
    end
    mem_ready = 1'b1;
    tick();
    @(negedge clk);
    check_eq("t4_we_done", 32'(mem_we), 32'd0);
    check_eq("t4_wcount", 32'(wcount), 32'd1);
    check_eq("t4_ready_back", 32'(in_ready), 32'd1);

    // Fill from BASE with wrap, then clear
    tick();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    for (int k = 0; k < 4; k++) begin
      send(k, k, k + 1, k + 2, k * 16);
      @(negedge clk);
      check_eq("t5_waddr", 32'(mem_waddr), 32'(exp_addr[k]));
      tick();
    end
    @(negedge clk);
    check_eq("t5_full", 32'(full), 32'd1);
    check_eq("t5_ready_full", 32'(in_ready), 32'd0);
    check_eq("t5_wcount", 32'(wcount), 32'd4);
    tick();
    send(1, 2, 3, 4, 16'h5555);
    @(negedge clk);
    check_eq("t5_no_write_full", 32'(mem_we), 32'd0);
    tick();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    @(negedge clk);
    check_eq("t5_full_clr", 32'(full), 32'd0);
    check_eq("t5_wcount_clr", 32'(wcount), 32'd0);
    tick();
    send(6, 9, 8, 7, 16'h0123);
    @(negedge clk);
    check_eq("t5_waddr_restart", 32'(mem_waddr), 32'd2);
    tick();

    // clear and reset during a pending write
    mem_ready = 1'b0;
    send(1, 4, 4, 0, 16'hCAFE);
    @(negedge clk);
    check_eq("t6_we_pend", 32'(mem_we), 32'd1);
    tick();
    clear = 1'b1;
    mem_ready = 1'b1;
    tick();
    clear = 1'b0;
    mem_ready = 1'b0;
    @(negedge clk);
    check_eq("t6_clr_we", 32'(mem_we), 32'd0);
    check_eq("t6_clr_wcount", 32'(wcount), 32'd0);
    tick();
    send(3, 1, 2, 0, 16'h1111);
    @(negedge clk);
    check_eq("t6_we_pend2", 32'(mem_we), 32'd1);
    tick();
    mem_ready = 1'b1;
    rst_n = 1'b0;
    #1;
    check_eq("t6_rst_we", 32'(mem_we), 32'd0);
    check_eq("t6_rst_ready", 32'(in_ready), 32'd0);
    check_eq("t6_rst_waddr", 32'(mem_waddr), 32'd2);
    check_eq("t6_rst_wdata", mem_wdata, 32'd0);
    check_eq("t6_rst_err_cnt", 32'(err_cnt), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();

    // Rejection counter saturation
    in_valid  = 1'b1;
    in_opcode = 3'd2;
    in_addr   = 16'h8000;
    repeat (260) tick();
    in_valid = 1'b0;
    @(negedge clk);
    check_eq("sat_err_cnt", 32'(err_cnt), 32'd255);
    tick();

    // Randomized traffic
    for (int i = 0; i < 1500; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_opcode = 3'($urandom_range(0, 7));
      in_r0     = 5'($urandom_range(0, 31));
      in_r1     = 5'($urandom_range(0, 31));
      in_r2     = 5'($urandom_range(0, 31));
      in_addr   = ($urandom_range(0, 3) != 0) ? 16'($urandom_range(0, 16383))
                                              : 16'($urandom_range(0, 65535));
      mem_ready = ($urandom_range(0, 9) < 6);
      clear     = ($urandom_range(0, 39) == 0);
      rst_n     = ($urandom_range(0, 299) != 0);
      tick();
    end
    in_valid = 1'b0;
    clear    = 1'b0;
    rst_n    = 1'b1;
    tick();
    @(negedge clk);
    #1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
